// File: rtl/risc_mem_arbiter_pkg.sv
// Shared types and defaults for the RISC unified-memory arbiter.
package risc_mem_arbiter_pkg;

    localparam int WIDTH_DEF    = 32;
    localparam int ADDRSIZE_DEF = 12;
    localparam int WAIT_MAX_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_t;

    // Width of the ACCESS wait counter; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/risc_mem_arbiter_pick.sv
// Combinational owner select between fetch and data requesters.
// RISC_ARB_RR_FAIR_EN: simultaneous requests go to the requester that did not own the last grant.
module risc_arb_pick
    import risc_mem_arbiter_pkg::*;
(
    input  logic   if_req,
    input  logic   dm_req,
`ifdef RISC_ARB_RR_FAIR_EN
    input  owner_t last_owner,
`endif
    output logic   any_req,
    output owner_t owner
);

    always_comb begin
        any_req = if_req | dm_req;
        owner   = OWN_IF;
        if (if_req && dm_req) begin
`ifdef RISC_ARB_RR_FAIR_EN
            owner = (last_owner == OWN_IF) ? OWN_DM : OWN_IF;
`else
            owner = OWN_DM;
`endif
        end else if (dm_req) begin
            owner = OWN_DM;
        end
    end

endmodule

// File: rtl/risc_mem_arbiter.sv
// Serialises fetch and data accesses onto one unified memory port with a stall timeout.
// Optional fairness on simultaneous requests: define RISC_ARB_RR_FAIR_EN.
module risc_mem_arbiter
    import risc_mem_arbiter_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEF,
    parameter int ADDRSIZE = ADDRSIZE_DEF,
    parameter int WAIT_MAX = WAIT_MAX_DEF
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                if_req,
    input  logic [ADDRSIZE-1:0] if_addr,
    output logic                if_gnt,
    output logic                if_valid,
    output logic [WIDTH-1:0]    if_rdata,
    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [ADDRSIZE-1:0] dm_addr,
    input  logic [WIDTH-1:0]    dm_wdata,
    output logic                dm_gnt,
    output logic                dm_valid,
    output logic [WIDTH-1:0]    dm_rdata,
    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDRSIZE-1:0] mem_addr,
    output logic [WIDTH-1:0]    mem_wdata,
    input  logic [WIDTH-1:0]    mem_rdata,
    input  logic                mem_ready,
    output logic                err,
    output logic                busy,
    output logic [1:0]          dbg_state
);

    localparam int            CW        = cnt_width(WAIT_MAX);
    localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_MAX - 1);

    // Handshake: a requester raises req with stable addr/data and holds it until its
    // 1-cycle valid pulse; gnt pulses in the first ACCESS cycle, valid in the RESP cycle.
    arb_state_t          state_q, state_d;
    owner_t              owner_q, owner_d;
    logic [CW-1:0]       wait_q, wait_d;
    logic                any_req;
    owner_t              pick_owner;
    logic                if_gnt_d, dm_gnt_d, if_valid_d, dm_valid_d, err_d, busy_d;
    logic                mem_en_d, mem_we_d;
    logic [ADDRSIZE-1:0] mem_addr_d;
    logic [WIDTH-1:0]    mem_wdata_d, if_rdata_d, dm_rdata_d;
`ifdef RISC_ARB_RR_FAIR_EN
    owner_t              last_owner_q, last_owner_d;
`endif

    risc_arb_pick u_pick (
        .if_req     (if_req),
        .dm_req     (dm_req),
`ifdef RISC_ARB_RR_FAIR_EN
        .last_owner (last_owner_q),
`endif
        .any_req    (any_req),
        .owner      (pick_owner)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        wait_d      = wait_q;
        if_gnt_d    = 1'b0;
        dm_gnt_d    = 1'b0;
        if_valid_d  = 1'b0;
        dm_valid_d  = 1'b0;
        err_d       = 1'b0;
        mem_en_d    = 1'b0;
        mem_we_d    = mem_we;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        if_rdata_d  = if_rdata;
        dm_rdata_d  = dm_rdata;
`ifdef RISC_ARB_RR_FAIR_EN
        last_owner_d = last_owner_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    state_d  = ST_ACCESS;
                    owner_d  = pick_owner;
                    wait_d   = '0;
                    mem_en_d = 1'b1;
`ifdef RISC_ARB_RR_FAIR_EN
                    last_owner_d = pick_owner;
`endif
                    if (pick_owner == OWN_DM) begin
                        dm_gnt_d    = 1'b1;
                        mem_we_d    = dm_we;
                        mem_addr_d  = dm_addr;
                        mem_wdata_d = dm_wdata;
                    end else begin
                        if_gnt_d    = 1'b1;
                        mem_we_d    = 1'b0;
                        mem_addr_d  = if_addr;
                        mem_wdata_d = '0;
                    end
                end
            end
            ST_ACCESS: begin
                mem_en_d = 1'b1;
                if (mem_ready || wait_q == WAIT_LAST) begin
                    state_d  = ST_RESP;
                    mem_en_d = 1'b0;
                    err_d    = ~mem_ready;
                    if (owner_q == OWN_DM) begin
                        dm_valid_d = 1'b1;
                        // Stores keep the previous load data unless the access timed out.
                        if (!mem_ready)   dm_rdata_d = '0;
                        else if (!mem_we) dm_rdata_d = mem_rdata;
                    end else begin
                        if_valid_d = 1'b1;
                        if_rdata_d = mem_ready ? mem_rdata : '0;
                    end
                end else begin
                    wait_d = wait_q + CW'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                wait_d  = '0;
            end
            default: begin
                state_d = ST_IDLE;
                wait_d  = '0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            owner_q   <= OWN_IF;
            wait_q    <= '0;
            if_gnt    <= 1'b0;
            dm_gnt    <= 1'b0;
            if_valid  <= 1'b0;
            dm_valid  <= 1'b0;
            err       <= 1'b0;
            busy      <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
`ifdef RISC_ARB_RR_FAIR_EN
            last_owner_q <= OWN_IF;
`endif
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            wait_q    <= wait_d;
            if_gnt    <= if_gnt_d;
            dm_gnt    <= dm_gnt_d;
            if_valid  <= if_valid_d;
            dm_valid  <= dm_valid_d;
            err       <= err_d;
            busy      <= busy_d;
            mem_en    <= mem_en_d;
            mem_we    <= mem_we_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            if_rdata  <= if_rdata_d;
            dm_rdata  <= dm_rdata_d;
`ifdef RISC_ARB_RR_FAIR_EN
            last_owner_q <= last_owner_d;
`endif
        end
    end

    assign dbg_state = state_q;

endmodule

// File: tb/tb_risc_mem_arbiter.sv
// Bench for risc_mem_arbiter: directed scenarios plus random traffic against a transaction-timing model.
module tb_risc_mem_arbiter;
    localparam int W  = 32;
    localparam int AW = 12;
    localparam int WM = 8;
`ifdef RISC_ARB_RR_FAIR_EN
    localparam logic [1:0] ORD_A = 2'b10;
    localparam logic [3:0] ORD_B = 4'b1010;
`else
    localparam logic [1:0] ORD_A = 2'b01;
    localparam logic [3:0] ORD_B = 4'b1111;
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0, mem_ready = 1'b0;
    logic [AW-1:0] if_addr = '0, dm_addr = '0;
    logic [W-1:0]  dm_wdata = '0, rd_junk = '0;
    logic          if_gnt, if_valid, dm_gnt, dm_valid, mem_en, mem_we, err, busy;
    logic [W-1:0]  if_rdata, dm_rdata, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;
    logic [1:0]    dbg_state;

    always #5 clk = ~clk;

    risc_mem_arbiter #(.WIDTH(W), .ADDRSIZE(AW), .WAIT_MAX(WM)) dut (
        .clk(clk), .reset_n(reset_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_valid(dm_valid), .dm_rdata(dm_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .err(err), .busy(busy), .dbg_state(dbg_state)
    );

    // Memory environment seen by the DUT.
    logic [W-1:0] env_mem [0:(1<<AW)-1];
    assign mem_rdata = mem_ready ? env_mem[mem_addr] : rd_junk;
    always @(posedge clk) if (mem_en && mem_ready && mem_we) env_mem[mem_addr] <= mem_wdata;

    int checks = 0, errors = 0;
    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin errors++; $display("FAIL %s actual=%b required=%b", nm, act, exp); end
    endtask
    task automatic chkw(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin errors++; $display("FAIL %s actual=%h required=%h", nm, act, exp); end
    endtask

    // Transaction model: one access at a time, timed by cycle numbers.
    logic [W-1:0]  ref_mem [0:(1<<AW)-1];
    int            cyc = 0, t_grant = 0, t_end = -1;
    bit            m_active = 1'b0, m_own = 1'b0, m_we = 1'b0, m_err = 1'b0, m_last = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [W-1:0]  m_wdata = '0, e_if_rdata = '0, e_dm_rdata = '0;
    bit            chk_en = 1'b0;

    always @(posedge clk) begin
        if (!reset_n) begin
            m_active = 1'b0; e_if_rdata = '0; e_dm_rdata = '0; m_last = 1'b0;
        end else if (m_active && t_end == cyc) begin
            m_active = 1'b0;
        end else if (m_active && t_end < 0) begin
            if (mem_ready) begin
                t_end = cyc + 1; m_err = 1'b0;
                if (m_we) ref_mem[m_addr] = m_wdata;
                else if (m_own) e_dm_rdata = ref_mem[m_addr];
                else e_if_rdata = ref_mem[m_addr];
            end else if (cyc - t_grant + 1 == WM) begin
                t_end = cyc + 1; m_err = 1'b1;
                if (m_own) e_dm_rdata = '0; else e_if_rdata = '0;
            end
        end else if (!m_active && (if_req || dm_req)) begin
`ifdef RISC_ARB_RR_FAIR_EN
            m_own = (if_req && dm_req) ? ~m_last : dm_req;
`else
            m_own = dm_req;
`endif
            m_last = m_own; m_active = 1'b1; t_grant = cyc + 1; t_end = -1;
            m_we = m_own ? dm_we : 1'b0;
            m_addr = m_own ? dm_addr : if_addr;
            m_wdata = dm_wdata;
        end
        cyc = cyc + 1;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            bit in_acc, in_resp;
            in_acc  = m_active && t_end < 0;
            in_resp = m_active && t_end == cyc;
            chk1("cmp_mem_en", mem_en, in_acc);
            chk1("cmp_busy", busy, m_active);
            chk1("cmp_if_gnt", if_gnt, m_active && cyc == t_grant && !m_own);
            chk1("cmp_dm_gnt", dm_gnt, m_active && cyc == t_grant && m_own);
            chk1("cmp_if_valid", if_valid, in_resp && !m_own);
            chk1("cmp_dm_valid", dm_valid, in_resp && m_own);
            chk1("cmp_err", err, in_resp && m_err);
            chkw("cmp_if_rdata", if_rdata, e_if_rdata);
            chkw("cmp_dm_rdata", dm_rdata, e_dm_rdata);
            if (in_acc) begin
                chk1("cmp_mem_we", mem_we, m_we);
                chkw("cmp_mem_addr", W'(mem_addr), W'(m_addr));
                if (m_we) chkw("cmp_mem_wdata", mem_wdata, m_wdata);
            end
        end
    end

    logic [W-1:0] exp_q[$];
    logic         got_q[$];
    int           n, en_cnt, last_v;

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            ref_mem[i] = $urandom; env_mem[i] = ref_mem[i];
        end
        ref_mem[5] = 32'h4000_1002; env_mem[5] = 32'h4000_1002;
        repeat (3) @(negedge clk);
        chk1("rst_mem_en", mem_en, 1'b0); chk1("rst_busy", busy, 1'b0);
        chk1("rst_gnt", if_gnt | dm_gnt, 1'b0); chk1("rst_valid", if_valid | dm_valid | err, 1'b0);
        chkw("rst_if_rdata", if_rdata, '0); chkw("rst_mem_addr", W'(mem_addr), '0);
        chkw("rst_dbg_state", W'(dbg_state), '0);
        reset_n = 1'b1; chk_en = 1'b1;

        // 1: single fetch, memory ready at once
        @(negedge clk); if_req = 1'b1; if_addr = 12'h005; mem_ready = 1'b1;
        @(negedge clk); chk1("t1_if_gnt", if_gnt, 1'b1); chk1("t1_mem_en", mem_en, 1'b1);
        @(negedge clk); chk1("t1_if_valid", if_valid, 1'b1); chk1("t1_err", err, 1'b0);
        chkw("t1_if_rdata", if_rdata, 32'h4000_1002);
        if_req = 1'b0; mem_ready = 1'b0;

        // 2: store stalled three cycles
        @(negedge clk); dm_req = 1'b1; dm_we = 1'b1; dm_addr = 12'h010; dm_wdata = 32'hDEAD_BEEF;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (i == 1) chk1("t2_dm_gnt", dm_gnt, 1'b1);
            chk1("t2_mem_en", mem_en, 1'b1); chk1("t2_mem_we", mem_we, 1'b1);
            chkw("t2_mem_addr", W'(mem_addr), 32'h10); chkw("t2_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
            if (i == 4) mem_ready = 1'b1;
        end
        @(negedge clk); chk1("t2_dm_valid", dm_valid, 1'b1); dm_req = 1'b0; dm_we = 1'b0; mem_ready = 1'b0;
        @(negedge clk); chk1("t2_valid_once", dm_valid, 1'b0); chkw("t2_mem16", env_mem[16], 32'hDEAD_BEEF);

        // 3a: simultaneous requests, each drops after its own valid
        if_req = 1'b1; if_addr = 12'h020; dm_req = 1'b1; dm_addr = 12'h010; mem_ready = 1'b1;
        got_q.delete(); n = 0;
        while ((if_req || dm_req) && n < 40) begin
            @(negedge clk); n++;
            if (if_gnt) got_q.push_back(1'b0);
            if (dm_gnt) got_q.push_back(1'b1);
            if (if_valid) if_req = 1'b0;
            if (dm_valid) dm_req = 1'b0;
        end
        chkw("t3a_grants", got_q.size(), 2);
        for (int i = 0; i < 2; i++) chk1($sformatf("t3a_order%0d", i), (i < got_q.size()) ? got_q[i] : 1'bx, ORD_A[i]);
        // 3b: both held continuously for four grants
        if_req = 1'b1; dm_req = 1'b1; got_q.delete(); n = 0;
        while (n < 80) begin
            @(negedge clk); n++;
            if (if_gnt) got_q.push_back(1'b0);
            if (dm_gnt) got_q.push_back(1'b1);
            if ((if_valid || dm_valid) && got_q.size() == 4) break;
        end
        if_req = 1'b0; dm_req = 1'b0;
        chkw("t3b_grants", got_q.size(), 4);
        for (int i = 0; i < 4; i++) chk1($sformatf("t3b_order%0d", i), (i < got_q.size()) ? got_q[i] : 1'bx, ORD_B[i]);

        // 4: memory never ready
        if_req = 1'b1; if_addr = 12'h007; mem_ready = 1'b0; en_cnt = 0; n = 0;
        while (n < 30) begin
            @(negedge clk); n++;
            if (mem_en) en_cnt++;
            if (if_valid) break;
        end
        chk1("t4_valid", if_valid, 1'b1); chk1("t4_err", err, 1'b1);
        chkw("t4_rdata", if_rdata, '0); chkw("t4_en_cycles", en_cnt, WM);
        if_req = 1'b0;
        @(negedge clk); chk1("t4_idle", busy, 1'b0);

        // 5: reset in the middle of an access
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 12'h003;
        repeat (3) @(negedge clk);
        reset_n = 1'b0; dm_req = 1'b0;
        @(negedge clk); chk1("t5_mem_en", mem_en, 1'b0); chk1("t5_busy", busy, 1'b0);
        chk1("t5_no_valid", dm_valid, 1'b0);
        reset_n = 1'b1;
        @(negedge clk); dm_req = 1'b1; dm_addr = 12'h010; mem_ready = 1'b1; n = 0;
        while (n < 20) begin @(negedge clk); n++; if (dm_valid) break; end
        chk1("t5_valid", dm_valid, 1'b1); chkw("t5_rdata", dm_rdata, 32'hDEAD_BEEF);
        dm_req = 1'b0;

        // 6: back-to-back fetches pc=0,1,2
        @(negedge clk);
        exp_q.delete();
        for (int i = 0; i < 3; i++) begin
            ref_mem[i] = 32'hC0DE_0000 + i; env_mem[i] = ref_mem[i]; exp_q.push_back(32'hC0DE_0000 + i);
        end
        if_req = 1'b1; if_addr = '0; n = 0; last_v = -1;
        while (if_req && n < 30) begin
            @(negedge clk); n++;
            if (if_valid) begin
                chkw("t6_rdata", if_rdata, exp_q.size() > 0 ? exp_q.pop_front() : 'x);
                if (last_v >= 0) chkw("t6_spacing", n - last_v, 3);
                last_v = n;
                if (if_addr == 12'd2) if_req = 1'b0; else if_addr = if_addr + 12'd1;
            end
        end
        chkw("t6_all_fetched", exp_q.size(), 0);
        mem_ready = 1'b0;

        // random traffic
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            mem_ready = ($urandom_range(0, 99) < ((c < 1000) ? 70 : 20));
            rd_junk = $urandom;
            if (if_req) begin
                if (if_valid) begin
                    if ($urandom_range(0, 1) == 1) if_addr = AW'($urandom_range(0, 63));
                    else if_req = 1'b0;
                end
            end else if ($urandom_range(0, 2) == 0) begin
                if_req = 1'b1; if_addr = AW'($urandom_range(0, 63));
            end
            if (dm_req) begin
                if (dm_valid) begin
                    if ($urandom_range(0, 1) == 1) begin
                        dm_we = $urandom_range(0, 1) == 1; dm_addr = AW'($urandom_range(0, 31)); dm_wdata = $urandom;
                    end else dm_req = 1'b0;
                end
            end else if ($urandom_range(0, 2) == 0) begin
                dm_req = 1'b1; dm_we = $urandom_range(0, 1) == 1;
                dm_addr = AW'($urandom_range(0, 31)); dm_wdata = $urandom;
            end
        end
        if_req = 1'b0; dm_req = 1'b0; mem_ready = 1'b1;
        repeat (15) @(negedge clk);
        chk1("end_idle", busy, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
